// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Ports: clk, reset (async, active-high), start/md_op/A/B launch an op,
//   hilo_we/hilo_sel write A to HI or LO when idle, busy flags a running op,
//   HI/LO expose the registers, out = hilo_sel ? LO : HI (combinational).
// Build option: define MD_UNIT_DIV_EN to enable DIV/DIVU; otherwise a
//   divide start is a no-op. Multiply timing/results are the same either way.
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic        op_ok, accept, done, wr_dir;
    logic [63:0] ax, bx, prod;
    logic [31:0] res_hi, res_lo;
    logic        res_we;

`ifdef MD_UNIT_DIV_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~md_op[1];
`endif

    // state register, counter and operand latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= md_op;
            end
        end
    end

    // next-state: counter is loaded with N-1 so completion lands on edge k+N
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (start && op_ok) begin
                    state_nx = RUN;
                    cnt_nx   = md_op[1] ? 4'd9 : 4'd4;
                end
            end
            RUN: begin
                if (cnt == 4'd0) state_nx = IDLE;
                else             cnt_nx   = cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // outputs; a start that is accepted takes priority over a direct write
    always_comb begin
        busy   = (state == RUN);
        accept = (state == IDLE) && start && op_ok;
        done   = (state == RUN) && (cnt == 4'd0);
        wr_dir = (state == IDLE) && hilo_we && !accept;
    end

    // one 64-bit multiplier; signed ops sign-extend, unsigned zero-extend
    assign ax   = {{32{~op_q[0] & a_q[31]}}, a_q};
    assign bx   = {{32{~op_q[0] & b_q[31]}}, b_q};
    assign prod = ax * bx;

`ifdef MD_UNIT_DIV_EN
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;

    // divide on magnitudes, then fix signs: quotient truncates toward
    // zero, remainder follows the dividend. 0x80000000/-1 falls out
    // naturally as 0x80000000 remainder 0.
    assign a_neg = ~op_q[0] & a_q[31];
    assign b_neg = ~op_q[0] & b_q[31];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign q_s   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r_s   = a_neg ? -r_mag : r_mag;

    assign res_hi = op_q[1] ? r_s : prod[63:32];
    assign res_lo = op_q[1] ? q_s : prod[31:0];
    // divide by zero leaves HI/LO untouched
    assign res_we = ~op_q[1] | (b_q != 32'd0);
`else
    assign res_hi = prod[63:32];
    assign res_lo = prod[31:0];
    assign res_we = ~op_q[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (done) begin
            if (res_we) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end else if (wr_dir) begin
            if (hilo_sel) LO <= A;
            else          HI <= A;
        end
    end

    assign out = hilo_sel ? LO : HI;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an
// arithmetic reference model (64-bit integer math on HI/LO).
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset, start, hilo_we, hilo_sel;
    logic [1:0]  md_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, out;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

`ifdef MD_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
        .busy(busy), .HI(HI), .LO(LO), .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference: results from plain 64-bit integer arithmetic
    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] a, b,
                                  inout logic [31:0] hi, lo,
                                  output int n);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'(a);
        ub = longint'(b);
        n  = 0;
        case (op)
            2'd0: begin
                sp = sa * sb;
                hi = sp[63:32];
                lo = sp[31:0];
                n  = 5;
            end
            2'd1: begin
                up = ua * ub;
                hi = up[63:32];
                lo = up[31:0];
                n  = 5;
            end
            default: begin
                if (DIV_EN) begin
                    n = 10;
                    if (b != 32'd0) begin
                        if (op == 2'd2) begin
                            sp = sa / sb;
                            lo = sp[31:0];
                            sp = sa % sb;
                            hi = sp[31:0];
                        end else begin
                            lo = a / b;
                            hi = a % b;
                        end
                    end
                end
            end
        endcase
    endfunction

    task automatic run(input logic [1:0] op, input logic [31:0] a, b,
                       input string tag, input bit rel);
        int n;
        int cnt;
        bit held;
        logic [31:0] eh, el;
        eh = m_hi;
        el = m_lo;
        model(op, a, b, eh, el, n);
        @(negedge clk);
        if (rel) reset = 1'b0;
        start = 1'b1; md_op = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; md_op = 2'($urandom);
        cnt  = 0;
        held = 1'b1;
        while (busy === 1'b1 && cnt < 20) begin
            if (HI !== m_hi || LO !== m_lo) held = 1'b0;
            cnt++;
            @(negedge clk);
        end
        chk({tag, " cycles"}, 32'(cnt), 32'(n));
        chk({tag, " held"}, 32'(held), 32'd1);
        chk({tag, " hi"}, HI, eh);
        chk({tag, " lo"}, LO, el);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        m_hi = eh;
        m_lo = el;
        hilo_sel = 1'($urandom);
        #1;
        chk({tag, " out"}, out, hilo_sel ? el : eh);
    endtask

    task automatic hw(input logic sel, input logic [31:0] v);
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b1; hilo_sel = sel; A = v;
        @(negedge clk);
        hilo_we = 1'b0;
        if (sel) m_lo = v;
        else     m_hi = v;
        chk("hw busy", 32'(busy), 32'd0);
        chk("hw hi", HI, m_hi);
        chk("hw lo", LO, m_lo);
        chk("hw out", out, sel ? m_lo : m_hi);
    endtask

    initial begin
        logic [31:0] eh, el, ra, rb;
        logic [1:0]  rop;
        int n, cnt;

        reset = 1'b1; start = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0;
        md_op = 2'd0; A = 32'd0; B = 32'd0;
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst hi", HI, 32'd0);
        chk("rst lo", LO, 32'd0);

        // start in the same cycle reset drops: taken at first edge
        run(2'd0, 32'hFFFFFFFE, 32'd3, "mult_neg", 1'b1);
        chk("mult_neg hi const", HI, 32'hFFFFFFFF);
        chk("mult_neg lo const", LO, 32'hFFFFFFFA);

        run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 1'b0);
        chk("multu hi const", HI, 32'hFFFFFFFE);
        chk("multu lo const", LO, 32'h00000001);

        run(2'd2, 32'hFFFFFFF9, 32'd2, "div_neg", 1'b0);
`ifdef MD_UNIT_DIV_EN
        chk("div_neg lo const", LO, 32'hFFFFFFFD);
        chk("div_neg hi const", HI, 32'hFFFFFFFF);
`endif

        hw(1'b0, 32'h11);
        hw(1'b1, 32'h22);
        run(2'd3, 32'd7, 32'd0, "divu_zero", 1'b0);
        chk("divu_zero hi const", HI, 32'h11);
        chk("divu_zero lo const", LO, 32'h22);

        run(2'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 1'b0);

        // start and hilo_we while busy are ignored
        eh = m_hi; el = m_lo;
        model(2'd0, 32'h00012345, 32'hFFFF0003, eh, el, n);
        @(negedge clk);
        start = 1'b1; md_op = 2'd0; A = 32'h00012345; B = 32'hFFFF0003;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            cnt++;
            if (cnt == 2) begin
                start = 1'b1; md_op = 2'd3; hilo_we = 1'b1;
                hilo_sel = 1'b1; A = 32'd99; B = 32'd7;
            end else begin
                start = 1'b0; hilo_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; hilo_we = 1'b0;
        chk("ign cycles", 32'(cnt), 32'd5);
        chk("ign hi", HI, eh);
        chk("ign lo", LO, el);
        m_hi = eh; m_lo = el;
        @(negedge clk);
        chk("ign busy after", 32'(busy), 32'd0);
        chk("ign lo after", LO, el);

        // reset mid-operation aborts with no write
        @(negedge clk);
        start = 1'b1; md_op = DIV_EN ? 2'd2 : 2'd0;
        A = 32'd1000; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", HI, 32'd0);
        chk("abort lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (12) @(negedge clk);
        chk("abort hi later", HI, 32'd0);
        chk("abort lo later", LO, 32'd0);
        chk("abort busy later", 32'(busy), 32'd0);

        // direct write, then start beating a simultaneous write
        hw(1'b1, 32'h1234);
        chk("mtlo const", out, 32'h1234);
        eh = m_hi; el = m_lo;
        model(2'd0, 32'h5555, 32'd2, eh, el, n);
        @(negedge clk);
        start = 1'b1; hilo_we = 1'b1; hilo_sel = 1'b1;
        md_op = 2'd0; A = 32'h5555; B = 32'd2;
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b0;
        chk("race lo kept", LO, 32'h1234);
        chk("race busy", 32'(busy), 32'd1);
        cnt = 1;
        while (busy === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("race cycles", 32'(cnt), 32'd6);
        chk("race lo", LO, el);
        chk("race hi", HI, eh);
        m_hi = eh; m_lo = el;

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) hw(1'($urandom), $urandom);
            run(rop, ra, rb, $sformatf("rnd%0d", i), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset: clk and reset, both 1-bit inputs; clk is listed first, reset second.
REQ-002 SHALL provide these ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- start  in  1  start request for the op on md_op
- md_op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- A  in  32  operand rs (dividend / multiplicand)
- B  in  32  operand rt (divisor / multiplier)
- hilo_we  in  1  direct write of HI or LO (MTHI/MTLO)
- hilo_sel  in  1  0=HI, 1=LO; selects both the write target and the read source
- busy  out  1  operation in progress
- HI  out  32  HI register
- LO  out  32  LO register
- out  out  32  combinational read: HI if hilo_sel=0, else LO (MFHI/MFLO)

Function
REQ-003 States SHALL be IDLE and RUN; a down-counter tracks remaining cycles.
REQ-004 In IDLE, start=1 at rising edge k SHALL latch A, B and md_op, load the counter, and enter RUN.
REQ-005 busy SHALL be 1 from edge k until edge k+N, where N=5 for MULT/MULTU and N=10 for DIV/DIVU.
REQ-006 At edge k+N, the unit SHALL write HI/LO, clear busy, and return to IDLE.
REQ-007 A new start SHALL be accepted at edge k+N+1 at the earliest.
REQ-008 start while busy=1 SHALL be ignored; the latched operands SHALL NOT change.
REQ-009 hilo_we while busy=1 SHALL be ignored.
REQ-010 In IDLE, hilo_we SHALL write A to HI or LO (per hilo_sel) at the next edge, with no busy.
REQ-011 If start and hilo_we are both 1 in IDLE, start SHALL win and the write SHALL be dropped.
REQ-012 MULT SHALL produce {HI,LO} = signed 64-bit A*B.
REQ-013 MULTU SHALL produce {HI,LO} = unsigned 64-bit A*B.
REQ-014 DIV SHALL produce LO = signed quotient truncated toward zero, and HI = remainder carrying the sign of the dividend.
REQ-015 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-016 DIVU SHALL produce LO = unsigned quotient and HI = unsigned remainder.
REQ-017 Division with B=0 SHALL still run the full 10 busy cycles and SHALL leave HI and LO unchanged.
REQ-018 HI and LO SHALL change only at the completion edge (REQ-006) or on a direct write (REQ-010); intermediate values SHALL NOT be visible.
REQ-019 out SHALL reflect the current HI/LO with no delay and SHALL be valid even while busy=1.

Reset
REQ-020 Asserting reset SHALL immediately force HI=0, LO=0, busy=0, state=IDLE and counter=0, regardless of clk.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no result written.
REQ-022 The first start after reset deassertion SHALL be accepted at the first rising edge where reset=0.

Configuration
REQ-023 With macro MD_UNIT_DIV_EN defined, DIV and DIVU SHALL be implemented as specified above.
REQ-024 With MD_UNIT_DIV_EN undefined, start with md_op=2 or 3 SHALL be a no-op: busy stays 0 and HI/LO are unchanged. Multiply behaviour SHALL be identical in both builds.

Verification
REQ-025 MULT with A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-026 MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-027 DIV with A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=0 and HI/LO preset to 0x11/0x22 -> HI=0x11, LO=0x22 after 10 cycles.
REQ-028 MULT start, then start(DIVU) plus hilo_we at busy cycle 2 -> both ignored; MULT result written at cycle 5; busy=0 at cycle 6.
REQ-029 Reset pulse asserted at busy cycle 3 of a DIV -> HI=LO=0 and busy=0 immediately; no later write.
REQ-030 In IDLE, hilo_we=1, hilo_sel=1, A=0x1234 -> LO=0x1234 next cycle and out=0x1234. With start=1 in the same cycle -> LO unchanged and the op starts.
